data_mem_pipe: RTL
==================

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; multiple of 8, range 8..128.
REQ-002 SHALL have parameter DEPTH, default 2048, memory depth in words; DEPTH <= 2^(ADDR_W - log2(DATA_W/8)).
REQ-003 SHALL have parameter ADDR_W, default 13, byte-address width.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_i  input  1  request valid.
REQ-007 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port be_i  input  DATA_W/8  byte enables, bit n -> wdata_i[8n+:8].
REQ-009 SHALL have port addr_i  input  ADDR_W  byte address; low log2(DATA_W/8) bits ignored.
REQ-010 SHALL have port wdata_i  input  DATA_W  write data.
REQ-011 SHALL have port gnt_o  output  1  request accepted when req_i && gnt_o.
REQ-012 SHALL have port rvalid_o  output  1  response valid.
REQ-013 SHALL have port rready_i  input  1  response consumed when rvalid_o && rready_i.
REQ-014 SHALL have port rdata_o  output  DATA_W  response data.
REQ-015 SHALL have port err_o  output  1  response error flag, qualified by rvalid_o.
REQ-016 SHALL have port init_done_o  output  1  memory ready.

Function
REQ-017 SHALL implement FSM states INIT, RUN, HOLD; INIT->RUN when clear counter reaches DEPTH-1; RUN->HOLD when rvalid_o && !rready_i; HOLD->RUN when rready_i.
REQ-018 SHALL drive gnt_o = 1 only in RUN, or in HOLD in the cycle rready_i = 1 (pass-through acceptance).
REQ-019 SHALL return every accepted request with exactly one response, rvalid_o high on the cycle after acceptance.
REQ-020 SHALL hold rvalid_o, rdata_o, err_o stable while rvalid_o && !rready_i.
REQ-021 SHALL, on accepted write, update only bytes with be_i set; write with be_i = 0 writes nothing but still responds.
REQ-022 SHALL return for a write response rdata_o = post-write word (write-first).
REQ-023 SHALL return for a read response the word at addr_i word index, reflecting all previously accepted writes including the one accepted the cycle before.
REQ-024 SHALL, when word index >= DEPTH, suppress the write, return rdata_o = 0 and err_o = 1; err_o = 0 otherwise.
REQ-025 SHALL drive init_done_o = 1 in RUN and HOLD, 0 in INIT.
REQ-026 SHALL ignore req_i while gnt_o = 0; no state change, no memory access.
REQ-027 SHALL sustain one accepted request per cycle while rready_i is held 1.

Reset
REQ-028 SHALL, on rst_ni low, asynchronously set rvalid_o = 0, err_o = 0, rdata_o = 0, clear counter = 0, FSM = INIT (macro defined) or RUN (macro undefined).
REQ-029 SHALL not reset memory contents through rst_ni directly.
REQ-030 SHALL, on reset asserted mid-clear or mid-response, drop the pending response and restart from REQ-028 state on release.

Configuration
REQ-031 SHALL use macro DATA_MEM_PIPE_INIT_CLEAR_EN.
REQ-032 SHALL, with macro defined, write 0 to word k in INIT cycle k (k = 0..DEPTH-1), gnt_o = 0 throughout, then enter RUN; init_done_o rises DEPTH cycles after reset release.
REQ-033 SHALL, with macro undefined, omit INIT and the clear counter; enter RUN directly; init_done_o = 1 from reset release; memory contents undefined until written.

Verification
REQ-034 SHALL cover: macro defined, reset release, DEPTH=16 -> init_done_o rises after 16 cycles; read any address -> rdata_o = 0, err_o = 0.
REQ-035 SHALL cover: write 0xAABBCCDD to 0x0010 be=1111, then write 0x11223344 be=0101 -> next read 0x0010 returns 0xAA22CC44.
REQ-036 SHALL cover: back-to-back write 0x12345678 @0x0020 then read @0x0020 on consecutive cycles, rready_i=1 -> read response 0x12345678, one response per cycle.
REQ-037 SHALL cover: read with rready_i=0 for 3 cycles -> gnt_o=0, rvalid_o and rdata_o stable 3 cycles; rready_i=1 -> new request accepted same cycle.
REQ-038 SHALL cover: DEPTH=2048, write 0xFFFFFFFF to byte address 0x2000 (ADDR_W=14) -> err_o=1, rdata_o=0; read @0x0000 unchanged.
REQ-039 SHALL cover: rst_ni low during INIT at cycle 5 and during HOLD -> rvalid_o=0 immediately; clear restarts at word 0 on release.

Source files
------------

// File: rtl/data_mem_pipe.sv
// Word memory with byte-enable writes and a one-entry response register (valid/ready).
// Optional power-up clear (INIT state) is compiled in when DATA_MEM_PIPE_INIT_CLEAR_EN is defined.
module data_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 13
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output logic                init_done_o
);
  localparam int NB     = DATA_W / 8;
  localparam int OFF    = $clog2(NB);
  localparam int IDX_W  = ADDR_W - OFF;
  localparam int MEM_AW = $clog2(DEPTH);

`ifdef DATA_MEM_PIPE_INIT_CLEAR_EN
  typedef enum logic [1:0] {INIT, RUN, HOLD} state_e;
`else
  typedef enum logic {RUN, HOLD} state_e;
`endif

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]    idx;
  logic                in_range;
  logic                accept;
  logic                mem_we;
  logic [MEM_AW-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   cur_word;
  logic [DATA_W-1:0]   merged;

  assign idx      = addr_i[ADDR_W-1:OFF];
  assign in_range = {1'b0, idx} < (IDX_W+1)'(DEPTH);
  assign cur_word = in_range ? mem[idx[MEM_AW-1:0]] : '0;

  if (OFF > 0) begin : g_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[OFF-1:0];
  end

  always_comb begin
    merged = cur_word;
    for (int unsigned b = 0; b < NB; b++) begin
      if (be_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

`ifdef DATA_MEM_PIPE_INIT_CLEAR_EN
  logic [MEM_AW-1:0] clr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               clr_cnt_q <= '0;
    else if (state_q == INIT)  clr_cnt_q <= clr_cnt_q + MEM_AW'(1);
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
`ifdef DATA_MEM_PIPE_INIT_CLEAR_EN
    if (!rst_ni) state_q <= INIT;
`else
    if (!rst_ni) state_q <= RUN;
`endif
    else         state_q <= state_d;
  end

  // RUN also withholds the grant while an unconsumed response is still on the
  // outputs, so a stalled response is never overwritten in the cycle before HOLD.
  always_comb begin
    state_d     = state_q;
    gnt_o       = 1'b0;
    init_done_o = 1'b1;
    mem_we      = 1'b0;
    mem_waddr   = idx[MEM_AW-1:0];
    mem_wdata   = merged;
    unique case (state_q)
`ifdef DATA_MEM_PIPE_INIT_CLEAR_EN
      INIT: begin
        init_done_o = 1'b0;
        mem_we      = 1'b1;
        mem_waddr   = clr_cnt_q;
        mem_wdata   = '0;
        if (clr_cnt_q == MEM_AW'(DEPTH-1)) state_d = RUN;
      end
`endif
      RUN: begin
        gnt_o = !rvalid_o || rready_i;
        if (rvalid_o && !rready_i) state_d = HOLD;
      end
      HOLD: begin
        gnt_o = rready_i;
        if (rready_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    accept = req_i && gnt_o;
    if (accept && we_i && in_range) mem_we = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else if (accept) begin
      rvalid_o <= 1'b1;
      rdata_o  <= !in_range ? '0 : (we_i ? merged : cur_word);
      err_o    <= !in_range;
    end else if (rready_i) begin
      rvalid_o <= 1'b0;
    end
  end

endmodule
